// File: rtl/pcie_dma_rd_ctrl.sv
// Host-to-card DMA read engine: issues 4DW MRd TLPs one at a time, reassembles the
// returning CplDs and pushes byte-swapped 128-bit words into the frame FIFO.
module pcie_dma_rd_ctrl #(
    parameter int RD_LEN_DW   = 32,
    parameter int FRAME_BYTES = 1843200,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic         pcie_clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [31:0]  rd_addr_low,
    input  logic [31:0]  rd_addr_high,
    input  logic [7:0]   ep_bus_num,
    input  logic [4:0]   ep_dev_num,
    input  logic         axis_master_tvalid,
    input  logic [127:0] axis_master_tdata,
    input  logic [3:0]   axis_master_tkeep,
    input  logic         axis_master_tlast,
    input  logic [7:0]   axis_master_tuser,
    output logic         axis_master_tready,
    input  logic         axis_slave_tready,
    output logic         axis_slave_tvalid,
    output logic [127:0] axis_slave_tdata,
    output logic         axis_slave_tlast,
    output logic [7:0]   axis_slave_tuser,
    input  logic         fifo_almost_full,
    output logic         fifo_wr_en,
    output logic [127:0] fifo_wr_data,
    output logic         busy,
    output logic         frame_done,
    output logic         rd_err
);
    // state      | meaning
    // S_IDLE     | waiting for start
    // S_WAIT_SPC | waiting for room for one request's worth of FIFO words
    // S_REQ      | MRd header presented on TX
    // S_WAIT_CPL | collecting CplD payload, timeout running
    // S_NEXT     | advance offset, finish frame or loop
    // S_ERR      | error parked until next start
    typedef enum logic [2:0] {S_IDLE, S_WAIT_SPC, S_REQ, S_WAIT_CPL, S_NEXT, S_ERR} state_t;

    localparam logic [10:0] RD_LEN   = 11'(RD_LEN_DW);
    localparam logic [31:0] STEP     = 32'(RD_LEN_DW * 4);
    localparam logic [31:0] FRAME_B  = 32'(FRAME_BYTES);
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYC - 1);

    state_t         state_q, state_d;
    logic [31:0]    base_lo_q, base_lo_d, base_hi_q, base_hi_d;
    logic [31:0]    offset_q, offset_d, tmo_q, tmo_d;
    logic [4:0]     tag_q, tag_d;
    logic [10:0]    rcvd_q, rcvd_d;
    logic           sof_q, sof_d, in_cpl_q, in_cpl_d;
    logic           rd_err_q, rd_err_d, frame_done_q, frame_done_d;
    logic           fifo_wr_en_q, fifo_wr_en_d;
    logic [127:0]   fifo_wr_data_q, fifo_wr_data_d;

    logic [15:0]    req_id;
    logic           hdr_beat, pay_beat, cpl_match, cpl_bad;
    logic [10:0]    cpl_len;
    logic [127:0]   swapped;
    logic           unused_ok;

    assign req_id    = {ep_bus_num, ep_dev_num, 3'b000};
    assign unused_ok = ^{axis_master_tkeep, axis_master_tuser, axis_master_tdata};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            swapped[32*k +: 32] = {axis_master_tdata[32*k +: 8], axis_master_tdata[32*k+8 +: 8],
                                   axis_master_tdata[32*k+16 +: 8], axis_master_tdata[32*k+24 +: 8]};
        end
    end

    // a zero length field encodes 1024 DW, which always overflows
    assign cpl_len   = (axis_master_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, axis_master_tdata[9:0]};
    assign hdr_beat  = axis_master_tvalid && sof_q;
    assign cpl_match = hdr_beat && (state_q == S_WAIT_CPL) && (axis_master_tdata[31:24] == 8'h4A)
                       && (axis_master_tdata[95:80] == req_id)
                       && (axis_master_tdata[79:72] == {3'b000, tag_q});
    assign cpl_bad   = (axis_master_tdata[47:45] != 3'b000) || ((rcvd_q + cpl_len) > RD_LEN);
    assign pay_beat  = axis_master_tvalid && !sof_q && in_cpl_q && (state_q == S_WAIT_CPL);

    always_comb begin
        state_d        = state_q;
        base_lo_d      = base_lo_q;
        base_hi_d      = base_hi_q;
        offset_d       = offset_q;
        tmo_d          = tmo_q;
        tag_d          = tag_q;
        rcvd_d         = rcvd_q;
        sof_d          = sof_q;
        in_cpl_d       = in_cpl_q;
        rd_err_d       = rd_err_q;
        frame_done_d   = 1'b0;
        fifo_wr_en_d   = 1'b0;
        fifo_wr_data_d = fifo_wr_data_q;

        if (axis_master_tvalid) sof_d = axis_master_tlast;

        if (pay_beat) begin
            fifo_wr_en_d   = 1'b1;
            fifo_wr_data_d = swapped;
            rcvd_d         = rcvd_q + 11'd4;
            if (axis_master_tlast) in_cpl_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    base_lo_d = rd_addr_low;
                    base_hi_d = rd_addr_high;
                    offset_d  = 32'd0;
                    rcvd_d    = 11'd0;
                    rd_err_d  = 1'b0;
                    state_d   = S_WAIT_SPC;
                end
            end
            S_WAIT_SPC: if (!fifo_almost_full) state_d = S_REQ;
            S_REQ: begin
                if (axis_slave_tready) begin
                    rcvd_d  = 11'd0;
                    tmo_d   = TMO_LOAD;
                    state_d = S_WAIT_CPL;
                end
            end
            S_WAIT_CPL: begin
                if (cpl_match && cpl_bad) begin
                    rd_err_d = 1'b1;
                    tag_d    = tag_q + 5'd1;
                    state_d  = S_ERR;
                end else if (cpl_match) begin
                    in_cpl_d = !axis_master_tlast;
                end else if (pay_beat && (rcvd_q + 11'd4 >= RD_LEN)) begin
                    tag_d   = tag_q + 5'd1;
                    state_d = S_NEXT;
                end else if (tmo_q == 32'd0) begin
                    rd_err_d = 1'b1;
                    tag_d    = tag_q + 5'd1;
                    state_d  = S_ERR;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
            end
            S_NEXT: begin
                offset_d = offset_q + STEP;
                if (offset_d == FRAME_B) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_WAIT_SPC;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != S_WAIT_CPL) in_cpl_d = 1'b0;
    end

    always_ff @(posedge pcie_clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            base_lo_q      <= 32'd0;
            base_hi_q      <= 32'd0;
            offset_q       <= 32'd0;
            tmo_q          <= 32'd0;
            tag_q          <= 5'd0;
            rcvd_q         <= 11'd0;
            sof_q          <= 1'b1;
            in_cpl_q       <= 1'b0;
            rd_err_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= 128'd0;
        end else begin
            state_q        <= state_d;
            base_lo_q      <= base_lo_d;
            base_hi_q      <= base_hi_d;
            offset_q       <= offset_d;
            tmo_q          <= tmo_d;
            tag_q          <= tag_d;
            rcvd_q         <= rcvd_d;
            sof_q          <= sof_d;
            in_cpl_q       <= in_cpl_d;
            rd_err_q       <= rd_err_d;
            frame_done_q   <= frame_done_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_wr_data_q <= fifo_wr_data_d;
        end
    end

    // header is a pure decode of registered state, so it is stable while REQ waits for tready
    assign axis_slave_tvalid  = (state_q == S_REQ);
    assign axis_slave_tdata   = (state_q == S_REQ) ?
        {base_lo_q + offset_q, base_hi_q, req_id, 3'b000, tag_q, 8'hFF,
         3'b001, 5'b00000, 14'd0, RD_LEN[9:0]} : 128'd0;
    assign axis_slave_tlast   = (state_q == S_REQ);
    assign axis_slave_tuser   = 8'h00;
    assign axis_master_tready = 1'b1;
    assign fifo_wr_en         = fifo_wr_en_q;
    assign fifo_wr_data       = fifo_wr_data_q;
    assign busy               = (state_q != S_IDLE);
    assign frame_done         = frame_done_q;
    assign rd_err             = rd_err_q;

endmodule

// File: tb/tb_pcie_dma_rd_ctrl.sv
// Directed bench for pcie_dma_rd_ctrl: 2-request frames, split/filtered completions,
// backpressure, error/timeout recovery and mid-request reset.
module tb_pcie_dma_rd_ctrl;
    logic         pcie_clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  rd_addr_low = 32'd0;
    logic [31:0]  rd_addr_high = 32'h0000_0001;
    logic [7:0]   ep_bus_num = 8'h12;
    logic [4:0]   ep_dev_num = 5'h03;
    logic         m_tvalid = 1'b0;
    logic [127:0] m_tdata = 128'd0;
    logic [3:0]   m_tkeep = 4'hF;
    logic         m_tlast = 1'b0;
    logic [7:0]   m_tuser = 8'h00;
    logic         m_tready;
    logic         s_tready = 1'b1;
    logic         s_tvalid;
    logic [127:0] s_tdata;
    logic         s_tlast;
    logic [7:0]   s_tuser;
    logic         fifo_almost_full = 1'b0;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic         busy, frame_done, rd_err;

    int checks = 0;
    int errors = 0;
    logic [127:0] wr_q[$];
    int fd_cnt = 0;

    localparam logic [15:0] RID = 16'h1218;

    pcie_dma_rd_ctrl #(.RD_LEN_DW(32), .FRAME_BYTES(256), .TIMEOUT_CYC(100)) dut (
        .pcie_clk(pcie_clk), .rstn(rstn), .start(start),
        .rd_addr_low(rd_addr_low), .rd_addr_high(rd_addr_high),
        .ep_bus_num(ep_bus_num), .ep_dev_num(ep_dev_num),
        .axis_master_tvalid(m_tvalid), .axis_master_tdata(m_tdata),
        .axis_master_tkeep(m_tkeep), .axis_master_tlast(m_tlast),
        .axis_master_tuser(m_tuser), .axis_master_tready(m_tready),
        .axis_slave_tready(s_tready), .axis_slave_tvalid(s_tvalid),
        .axis_slave_tdata(s_tdata), .axis_slave_tlast(s_tlast), .axis_slave_tuser(s_tuser),
        .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .busy(busy), .frame_done(frame_done), .rd_err(rd_err)
    );

    always #5 pcie_clk = ~pcie_clk;

    always @(negedge pcie_clk) begin
        if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge pcie_clk);
            #1;
        end
    endtask

    function automatic logic [31:0] mk_dw(input logic [7:0] seed, input int i);
        logic [7:0] ib;
        ib = i[7:0];
        return {seed, ib, 8'h5A, 8'hC3};
    endfunction

    // bytes of each payload DW reversed, DW order kept
    function automatic logic [127:0] exp_word(input logic [7:0] seed, input int beat);
        logic [127:0] w;
        logic [7:0] ib;
        for (int k = 0; k < 4; k++) begin
            ib = 8'(4 * beat + k);
            w[32*k +: 32] = {8'hC3, 8'h5A, ib, seed};
        end
        return w;
    endfunction

    function automatic logic [127:0] mrd_hdr(input logic [31:0] lo, input logic [4:0] tag);
        return {lo, 32'h0000_0001, RID, 3'b000, tag, 8'hFF, 32'h2000_0020};
    endfunction

    function automatic logic [127:0] tlp_hdr(input logic [7:0] fmt_type, input logic [15:0] rid,
                                             input logic [4:0] tag, input int ndw,
                                             input logic [2:0] st);
        return {32'h0, rid, 3'b000, tag, 8'h00, 16'h0000, st, 1'b0, 12'(ndw * 4),
                fmt_type, 14'd0, 10'(ndw)};
    endfunction

    // header beat then ndw/4 payload beats, back to back
    task automatic send_tlp(input logic [127:0] hdr, input int ndw, input logic [7:0] seed,
                            input int first_beat);
        m_tvalid = 1'b1;
        m_tdata  = hdr;
        m_tlast  = (ndw == 0);
        step();
        for (int b = 0; b < ndw / 4; b++) begin
            for (int k = 0; k < 4; k++) m_tdata[32*k +: 32] = mk_dw(seed, 4 * (first_beat + b) + k);
            m_tlast = (b == ndw / 4 - 1);
            step();
        end
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = 128'd0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!s_tvalid && n < 200) begin
            step();
            n++;
        end
        if (!s_tvalid) chk({tag, "_timeout"}, {127'd0, s_tvalid}, 128'd1);
    endtask

    task automatic do_start(input logic [31:0] lo);
        rd_addr_low = lo;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int base;
        // reset values
        #2;
        chk("rst_tvalid", {127'd0, s_tvalid}, 128'd0);
        chk("rst_tdata", s_tdata, 128'd0);
        chk("rst_misc", {s_tlast, s_tuser, fifo_wr_en, busy, frame_done, rd_err}, 128'd0);
        chk("rst_mready", {127'd0, m_tready}, 128'd1);
        chk("rst_wrdata", fifo_wr_data, 128'd0);
        step(2);
        rstn = 1'b1;
        step();

        // basic read: two requests, one CplD each
        do_start(32'h1000_0000);
        chk("basic_busy", {127'd0, busy}, 128'd1);
        step();
        chk("start_to_tvalid", {127'd0, s_tvalid}, 128'd1);
        chk("hdr0", s_tdata, mrd_hdr(32'h1000_0000, 5'd0));
        chk("hdr0_last_user", {s_tlast, s_tuser}, {119'd0, 1'b1, 8'h00});
        step();
        chk("tvalid_drop", {127'd0, s_tvalid}, 128'd0);
        send_tlp(tlp_hdr(8'h4A, RID, 5'd0, 32, 3'b000), 32, 8'h11, 0);
        wait_req("req1");
        chk("hdr1", s_tdata, mrd_hdr(32'h1000_0080, 5'd1));
        step();
        send_tlp(tlp_hdr(8'h4A, RID, 5'd1, 32, 3'b000), 32, 8'h22, 0);
        chk("last_wr_en", {126'd0, fifo_wr_en, busy}, 128'd3);
        step();
        chk("frame_done_pulse", {126'd0, frame_done, busy}, 128'd2);
        chk("wr_en_low", {127'd0, fifo_wr_en}, 128'd0);
        step();
        chk("frame_done_once", {127'd0, frame_done}, 128'd0);
        chk("basic_wr_cnt", 128'(wr_q.size()), 128'd16);
        for (int j = 0; j < 8; j++) begin
            chk("basic_data_a", wr_q[j], exp_word(8'h11, j));
            chk("basic_data_b", wr_q[8 + j], exp_word(8'h22, j));
        end

        // almost_full gating, TX backpressure, filtering, split completion
        fifo_almost_full = 1'b1;
        do_start(32'h2000_0000);
        step(5);
        chk("af_no_req", {126'd0, s_tvalid, busy}, 128'd1);
        s_tready = 1'b0;
        fifo_almost_full = 1'b0;
        wait_req("req2");
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold", s_tdata, mrd_hdr(32'h2000_0000, 5'd2));
            chk("bp_valid", {127'd0, s_tvalid}, 128'd1);
            step();
        end
        s_tready = 1'b1;
        step();
        base = wr_q.size();
        send_tlp(tlp_hdr(8'h40, RID, 5'd2, 8, 3'b000), 8, 8'h33, 0);
        send_tlp(tlp_hdr(8'h4A, RID, 5'd3, 32, 3'b000), 32, 8'h44, 0);
        send_tlp(tlp_hdr(8'h4A, 16'h1220, 5'd2, 32, 3'b000), 32, 8'h55, 0);
        start = 1'b1;
        rd_addr_low = 32'h7000_0000;
        step();
        start = 1'b0;
        step(2);
        chk("filter_no_wr", 128'(wr_q.size() - base), 128'd0);
        chk("filter_state", {126'd0, busy, s_tvalid}, 128'd2);
        send_tlp(tlp_hdr(8'h4A, RID, 5'd2, 16, 3'b000), 16, 8'h66, 0);
        step(3);
        chk("split_no_req", {127'd0, s_tvalid}, 128'd0);
        chk("split_half_cnt", 128'(wr_q.size() - base), 128'd4);
        send_tlp(tlp_hdr(8'h4A, RID, 5'd2, 16, 3'b000), 16, 8'h66, 4);
        wait_req("req3");
        chk("split_cnt", 128'(wr_q.size() - base), 128'd8);
        chk("split_err", {127'd0, rd_err}, 128'd0);
        chk("split_data0", wr_q[base], exp_word(8'h66, 0));
        chk("split_data7", wr_q[base + 7], exp_word(8'h66, 7));
        chk("hdr3_busy_start_ignored", s_tdata, mrd_hdr(32'h2000_0080, 5'd3));
        step();
        send_tlp(tlp_hdr(8'h4A, RID, 5'd3, 32, 3'b000), 32, 8'h77, 0);
        step(2);
        chk("frame2_done", 128'(fd_cnt), 128'd2);

        // completion with error status
        do_start(32'h3000_0000);
        wait_req("req4");
        chk("hdr4", s_tdata, mrd_hdr(32'h3000_0000, 5'd4));
        step();
        base = wr_q.size();
        send_tlp(tlp_hdr(8'h4A, RID, 5'd4, 32, 3'b001), 32, 8'h88, 0);
        step(2);
        chk("status_err", {126'd0, rd_err, busy}, 128'd3);
        chk("status_no_wr", 128'(wr_q.size() - base), 128'd0);

        // restart clears rd_err; then completion timeout
        do_start(32'h4000_0000);
        chk("err_cleared", {126'd0, rd_err, busy}, 128'd1);
        wait_req("req5");
        chk("hdr5", s_tdata, mrd_hdr(32'h4000_0000, 5'd5));
        step();
        step(50);
        chk("tmo_early", {126'd0, rd_err, busy}, 128'd1);
        step(60);
        chk("tmo_err", {126'd0, rd_err, busy}, 128'd3);
        send_tlp(tlp_hdr(8'h4A, RID, 5'd5, 32, 3'b000), 32, 8'h99, 0);
        step(2);
        chk("late_cpl_dropped", 128'(wr_q.size() - base), 128'd0);

        // asynchronous reset while waiting for a completion
        do_start(32'h5000_0000);
        wait_req("req6");
        chk("hdr6", s_tdata, mrd_hdr(32'h5000_0000, 5'd6));
        step();
        rstn = 1'b0;
        #1;
        chk("arst_outs", {s_tvalid, s_tlast, s_tuser, fifo_wr_en, busy, frame_done, rd_err},
            128'd0);
        chk("arst_mready", {127'd0, m_tready}, 128'd1);
        step();
        rstn = 1'b1;
        send_tlp(tlp_hdr(8'h4A, RID, 5'd6, 32, 3'b000), 32, 8'hAA, 0);
        step(2);
        chk("arst_no_wr", 128'(wr_q.size() - base), 128'd0);
        chk("arst_idle", {126'd0, busy, fifo_wr_en}, 128'd0);
        do_start(32'h6000_0000);
        wait_req("req7");
        chk("tag_reset", s_tdata, mrd_hdr(32'h6000_0000, 5'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_dma_rd_ctrl.md
# pcie_dma_rd_ctrl

Host-to-card DMA read engine on the PCIe user AXI-Stream interface. On `start` it reads a frame buffer out of host memory as a series of 4DW memory-read (MRd) TLPs, one request outstanding at a time. It reassembles the returning completion-with-data (CplD) TLPs, byte-swaps each DW and pushes 128-bit words into a downstream frame FIFO feeding the video output path. It shares the core's RX/TX streams with the card-to-host write controller through the existing arbiter/mux.

## Interface
Parameters:
- RD_LEN_DW, 32: DW per MRd request. Must be a multiple of 4 and ≤ 128.
- FRAME_BYTES, 1843200: bytes per frame (1280×720×2). Must be a multiple of RD_LEN_DW×4.
- TIMEOUT_CYC, 65535: pcie_clk cycles allowed for a request's full completion.

Ports:
- pcie_clk, in, 1: sole clock.
- rstn, in, 1: reset, asynchronous, active-low.
- start, in, 1: level-sampled in IDLE; begins a frame read.
- rd_addr_low, in, 32: frame base address bits [31:0]. Must be 128-byte aligned.
- rd_addr_high, in, 32: frame base address bits [63:32].
- ep_bus_num, in, 8: requester bus number.
- ep_dev_num, in, 5: requester device number (function = 0).
- axis_master_tvalid / tdata[127:0] / tkeep[3:0] / tlast / tuser[7:0], in: RX TLPs from the core.
- axis_master_tready, out, 1: tied 1.
- axis_slave_tready, in, 1: TX ready from the core.
- axis_slave_tvalid / tdata[127:0] / tlast / tuser, out: TX request TLP.
- fifo_almost_full, in, 1: downstream FIFO has fewer than RD_LEN_DW/4 free words.
- fifo_wr_en, out, 1: write strobe.
- fifo_wr_data, out, 128: write data.
- busy, out, 1: high whenever the state is not IDLE.
- frame_done, out, 1: one-cycle pulse after the last word of a frame is written.
- rd_err, out, 1: sticky error flag; cleared on the next accepted start.

## Operation
- States are IDLE, WAIT_SPACE, REQ, WAIT_CPL, NEXT, ERR.
  - IDLE: on start, latch the base address, clear offset, remaining-DW and rd_err; go to WAIT_SPACE.
  - WAIT_SPACE: go to REQ when fifo_almost_full=0.
  - REQ: drive a single-beat header with tlast=1. Go to WAIT_CPL on tvalid&tready.
  - WAIT_CPL: accept completions until RD_LEN_DW DW have been received, then go to NEXT.
  - NEXT: offset += RD_LEN_DW×4. If offset = FRAME_BYTES, pulse frame_done and go to IDLE; otherwise go to WAIT_SPACE. tag increments (5-bit wrap) on every request.
  - ERR: hold until start, then behave as IDLE.
- MRd header fields:
  - [9:0]=RD_LEN_DW, [31:29]=3'b001, [28:24]=0, all other DW0 bits 0.
  - [35:32]=4'hf, [39:36]=4'hf, [47:40]={3'b0,tag}, [63:48]={ep_bus_num,ep_dev_num,3'b0}.
  - [95:64]=rd_addr_high, [127:96]=rd_addr_low+offset (carry into the high DW is not supported).
- axis_slave_tuser is always 0.
- The RX header is the first beat of a TLP, detected as tvalid with the previous beat's tlast (or first beat after reset).
- A completion is accepted when {tdata[31:29],tdata[28:24]}=8'h4A, requester ID [95:80] matches, tag [79:72] matches the current tag, and the state is WAIT_CPL. All other TLPs are ignored for their whole length.
- Completion status [47:45]≠0, or a length that would overflow RD_LEN_DW, sets rd_err and moves to ERR.
- Payload starts at the beat after the header, with DW0 in [31:0].
  - Each payload beat is written with each DW byte-reversed: DWn bytes {b0,b1,b2,b3} → {b3,b2,b1,b0}, DW order kept.
  - Received-DW count += 4 per beat.
- Split completions (64-byte RCB) are accumulated. In-order only.
- Timeout: a counter runs in WAIT_CPL. Reaching TIMEOUT_CYC sets rd_err and moves to ERR; late completions are dropped.

## Timing
- Reset values: all outputs 0 except axis_master_tready=1. State is IDLE, tag=0.
- start→first TX tvalid: 2 cycles, given fifo_almost_full=0.
- TX tvalid and tdata stay stable until tready. tvalid deasserts the cycle after acceptance.
- fifo_wr_en/fifo_wr_data are registered, one cycle after the payload beat is accepted. There is no backpressure to the FIFO; the almost_full gating guarantees space.
- A start while busy=1 is ignored.
- Asynchronous reset mid-request aborts immediately. Completions arriving afterwards are dropped because the state is IDLE.
- frame_done is asserted the same cycle as the entry into IDLE, one cycle after the final fifo_wr_en.

## Test plan
- **Basic read:** FRAME_BYTES=256, base 0x1000_0000, start. Expect two MRd TLPs: addr 0x1000_0000 tag 0, then 0x1000_0080 tag 1, each length 32. Reply with a single CplD each. Expect 16 fifo writes with DW bytes reversed, then a frame_done pulse.
- **Split completion:** answer one MRd with two 16-DW CplDs. Expect 8 writes and no error. The next request is only issued after the second CplD.
- **Filtering:** inject an MWr (0x40), a CplD with the wrong tag, and a CplD with the wrong requester ID during WAIT_CPL. Expect no fifo writes and no state change.
- **Backpressure:** hold axis_slave_tready=0 for 5 cycles; the header must be held stable. Hold fifo_almost_full=1; no request may be issued until it drops.
- **Errors:** a CplD with status 3'b001, and separately no completion for TIMEOUT_CYC=100. Expect rd_err=1 and busy staying high in ERR; the next start clears rd_err.
- **Reset mid-frame:** assert rstn=0 in WAIT_CPL, then send the CplD. Expect all outputs at reset values and no fifo writes.
